// File: rtl/le_arbiter.sv
// Round-robin arbiter sharing one signed a<=b comparator between N stb/ack requesters.
// One operation in flight at a time: grant, latch operands, wait LATENCY, return result.

module le #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             z
);
  logic cmp;
  assign cmp = $signed(a) <= $signed(b);

  generate
    if (STAGES > 0) begin : g_pipe
      logic [STAGES-1:0] pipe_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          pipe_q <= '0;
        end else begin
          pipe_q[0] <= cmp;
          for (int i = 1; i < STAGES; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end
      assign z = pipe_q[STAGES-1];
    end else begin : g_comb
      logic unused_clk;
      assign unused_clk = clk ^ rst;
      assign z = cmp;
    end
  endgenerate
endmodule

module le_arbiter #(
  parameter int WIDTH   = 32,
  parameter int N       = 4,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N*WIDTH-1:0] in_a,
  input  logic [N*WIDTH-1:0] in_b,
  input  logic [N-1:0]     in_stb,
  output logic [N-1:0]     in_ack,
  output logic [N-1:0]     out_z,
  output logic [N-1:0]     out_z_stb,
  input  logic [N-1:0]     out_z_ack,
  output logic             busy
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    g_q, g_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             res_q, res_d;
  logic             le_z;
  logic             found;
  logic [PW-1:0]    scan_idx;

  // The comparator's last stage is res_q, so le itself carries LATENCY-1 stages.
  le #(
    .WIDTH (WIDTH),
    .STAGES((LATENCY > 1) ? LATENCY - 1 : 0)
  ) u_le (
    .clk(clk),
    .rst(rst),
    .a  (op_a_q),
    .b  (op_b_q),
    .z  (le_z)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      g_q     <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      cnt_q   <= '0;
      res_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    g_d      = g_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    found    = 1'b0;
    scan_idx = '0;
    case (state_q)
      IDLE: begin
        for (int i = 0; i < N; i++) begin
          if (!found) begin
            scan_idx = PW'((int'(ptr_q) + i) % N);
            if (in_stb[scan_idx]) begin
              found   = 1'b1;
              g_d     = scan_idx;
              state_d = ISSUE;
            end
          end
        end
      end
      ISSUE: begin
        // A requester that withdrew before the ack edge is simply dropped.
        if (in_stb[g_q]) begin
          op_a_d  = in_a[int'(g_q)*WIDTH +: WIDTH];
          op_b_d  = in_b[int'(g_q)*WIDTH +: WIDTH];
          cnt_d   = CW'(LATENCY);
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q <= CW'(1)) begin
          res_d   = le_z;
          state_d = RESPOND;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESPOND: begin
        if (out_z_ack[g_q]) begin
          ptr_d   = (g_q == PW'(N - 1)) ? '0 : g_q + PW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ack    = '0;
    out_z_stb = '0;
    out_z     = '0;
    if (state_q == ISSUE) in_ack[g_q] = 1'b1;
    if (state_q == RESPOND) begin
      out_z_stb[g_q] = 1'b1;
      out_z[g_q]     = res_q;
    end
  end

  assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_le_arbiter.sv
// Directed bench for le_arbiter: single ops, fairness, wrap, backpressure, abandon, reset.
module tb_le_arbiter;
  localparam int W = 32;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] in_a, in_b;
  logic [N-1:0]   in_stb, in_ack, out_z, out_z_stb, out_z_ack;
  logic           busy;

  int n_chk = 0;
  int n_err = 0;

  le_arbiter #(.WIDTH(W), .N(N), .LATENCY(1)) dut (
    .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_stb(in_stb),
    .in_ack(in_ack), .out_z(out_z), .out_z_stb(out_z_stb),
    .out_z_ack(out_z_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
    in_a[k*W +: W] = a;
    in_b[k*W +: W] = b;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ack"}, 32'(in_ack), 32'd0);
    chk({tag, "_stb"}, 32'(out_z_stb), 32'd0);
    chk({tag, "_z"}, 32'(out_z), 32'd0);
  endtask

  // Serve the grant for k (in_stb[k] already high, k must win the next IDLE scan).
  task automatic serve(input string tag, input int k, input bit expz, input int stall, input int bogus);
    logic [N-1:0] one;
    one = '0;
    one[k] = 1'b1;
    tick();
    chk({tag, "_ack"}, 32'(in_ack), 32'(one));
    tick();
    in_stb[k] = 1'b0;
    chk({tag, "_wait_ack"}, 32'(in_ack), 32'd0);
    chk({tag, "_wait_stb"}, 32'(out_z_stb), 32'd0);
    tick();
    chk({tag, "_stb"}, 32'(out_z_stb), 32'(one));
    chk({tag, "_z"}, 32'(out_z), expz ? 32'(one) : 32'd0);
    if (bogus >= 0) out_z_ack[bogus] = 1'b1;
    for (int s = 0; s < stall; s++) begin
      tick();
      chk({tag, "_hold_stb"}, 32'(out_z_stb), 32'(one));
      chk({tag, "_hold_z"}, 32'(out_z), expz ? 32'(one) : 32'd0);
    end
    out_z_ack = '0;
    out_z_ack[k] = 1'b1;
    tick();
    out_z_ack = '0;
    chk({tag, "_done_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done_stb"}, 32'(out_z_stb), 32'd0);
  endtask

  task automatic do_op(input string tag, input int k, input logic [W-1:0] a, input logic [W-1:0] b, input bit expz);
    set_ops(k, a, b);
    in_stb[k] = 1'b1;
    serve(tag, k, expz, 0, -1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_a = '0; in_b = '0; in_stb = '0; out_z_ack = '0;
    do_reset();
    chk_idle("reset");

    // single requester
    do_op("s1", 0, 32'd5, 32'd7, 1'b1);
    do_op("s2", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    do_op("s3", 0, 32'h8000_0000, 32'h8000_0000, 1'b1);

    // fairness: all held from reset, served 0,1,2,3 back to back
    do_reset();
    set_ops(0, 32'd1, 32'd2);
    set_ops(1, 32'd3, 32'd2);
    set_ops(2, 32'hFFFF_FFFB, 32'hFFFF_FFFB);
    set_ops(3, 32'h7FFF_FFFF, 32'h8000_0000);
    in_stb = 4'hF;
    serve("f0", 0, 1'b1, 0, -1);
    serve("f1", 1, 1'b0, 0, -1);
    serve("f2", 2, 1'b1, 0, -1);
    serve("f3", 3, 1'b0, 0, -1);

    // wrap: after 2, with 0 and 3 pending, 3 goes first
    do_op("w2", 2, 32'd0, 32'd1, 1'b1);
    set_ops(0, 32'd9, 32'd8);
    set_ops(3, 32'hFFFF_FFF0, 32'd0);
    in_stb[0] = 1'b1;
    in_stb[3] = 1'b1;
    serve("w3", 3, 1'b1, 0, -1);
    serve("w0", 0, 1'b0, 0, -1);

    // backpressure on 1 with a stray ack on 2
    set_ops(1, 32'd10, 32'hFFFF_FFFD);
    in_stb[1] = 1'b1;
    serve("bp", 1, 1'b0, 5, 2);

    // abandoned request leaves ptr at 0
    do_reset();
    in_stb[0] = 1'b1;
    tick();
    chk("ab_ack", 32'(in_ack), 32'd1);
    in_stb[0] = 1'b0;
    tick();
    chk_idle("ab_idle");
    tick();
    chk_idle("ab_idle2");
    set_ops(0, 32'd4, 32'd4);
    set_ops(1, 32'd5, 32'd4);
    in_stb[0] = 1'b1;
    in_stb[1] = 1'b1;
    serve("ab0", 0, 1'b1, 0, -1);
    serve("ab1", 1, 1'b0, 0, -1);

    // reset during WAIT
    set_ops(2, 32'd1, 32'd1);
    in_stb[2] = 1'b1;
    tick();
    chk("rw_ack", 32'(in_ack), 32'h4);
    tick();
    in_stb[2] = 1'b0;
    rst = 1'b1;
    tick();
    chk_idle("rw_rst");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle("rw_after");
    end

    // reset during RESPOND (ptr back to 0 then 1 is ahead of 3)
    set_ops(2, 32'd1, 32'd1);
    in_stb[2] = 1'b1;
    tick();
    tick();
    in_stb[2] = 1'b0;
    tick();
    chk("rr_stb", 32'(out_z_stb), 32'h4);
    rst = 1'b1;
    tick();
    chk_idle("rr_rst");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle("rr_after");
    end
    set_ops(1, 32'h8000_0000, 32'h7FFF_FFFF);
    set_ops(3, 32'd100, 32'd99);
    in_stb[1] = 1'b1;
    in_stb[3] = 1'b1;
    serve("rr1", 1, 1'b1, 0, -1);
    serve("rr3", 3, 1'b0, 0, -1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
